// File: rtl/ec_dec_bitstream_refill.sv
// Decoder bitstream refill: keeps an MSB-aligned window of inverted coded bytes
// and serves variable-length shifts to the arithmetic decoder core.
module ec_dec_bitstream_refill #(
  parameter int WINDOW_WIDTH = 32,
  parameter int COUNT_WIDTH  = 16,
  parameter int PAD_LIMIT    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  input  logic                   shift_valid,
  input  logic [3:0]             shift_amt,
  output logic [15:0]            win_out,
  output logic                   win_valid,
  output logic [COUNT_WIDTH-1:0] bytes_consumed,
  output logic                   tail_active,
  output logic                   overread,
  output logic                   underflow_err
);

  localparam int VB_W  = $clog2(WINDOW_WIDTH + 1);
  localparam int PAD_W = $clog2(PAD_LIMIT + 17);
  localparam logic [VB_W-1:0]  SPACE_MAX = VB_W'(WINDOW_WIDTH - 8);
  localparam logic [VB_W-1:0]  VB_16     = VB_W'(16);
  localparam logic [VB_W-1:0]  VB_8      = VB_W'(8);
  localparam logic [PAD_W-1:0] PAD_LIM   = PAD_W'(PAD_LIMIT);

  typedef enum logic [1:0] {IDLE, FILL, RUN, TAIL} state_t;

  state_t                  state_q, state_d;
  logic [WINDOW_WIDTH-1:0] window_q, window_d;
  logic [VB_W-1:0]         vb_q, vb_d;
  logic [PAD_W-1:0]        pad_q, pad_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    ovr_q, ovr_d;
  logic                    unf_q, unf_d;
  logic                    win_valid_q, win_valid_d;
  logic [15:0]             win_out_q, win_out_d;

  logic                    shift_ok, byte_ok;
  logic [VB_W-1:0]         amt_v, vb_sh, pos;
  logic [WINDOW_WIDTH-1:0] ones_w, win_sh;
  logic [7:0]              inv_byte;
  logic [PAD_W:0]          pad_sum;

  // Space is judged on the registered fill level only.
  assign in_ready = ((state_q == FILL) || (state_q == RUN)) && (vb_q <= SPACE_MAX);

  always_comb begin
    state_d     = state_q;
    window_d    = window_q;
    vb_d        = vb_q;
    pad_d       = pad_q;
    cnt_d       = cnt_q;
    ovr_d       = ovr_q;
    unf_d       = unf_q;
    shift_ok    = shift_valid && win_valid_q;
    byte_ok     = in_valid && in_ready;
    amt_v       = {{(VB_W-4){1'b0}}, shift_amt};
    ones_w      = '1;
    inv_byte    = ~in_byte;
    win_sh      = window_q;
    vb_sh       = vb_q;
    pad_sum     = '0;
    pos         = '0;

    if (shift_valid && !win_valid_q) unf_d = 1'b1;

    if (shift_ok) begin
      win_sh = (window_q << shift_amt) | ~(ones_w << shift_amt);
      if (vb_q >= amt_v) begin
        vb_sh = vb_q - amt_v;
      end else begin
        // Only reachable in TAIL: bits beyond the real data are ones padding.
        vb_sh   = '0;
        pad_sum = {1'b0, pad_q} + (PAD_W + 1)'(amt_v - vb_q);
        pad_d   = pad_sum[PAD_W] ? '1 : pad_sum[PAD_W-1:0];
      end
    end
    window_d = win_sh;
    vb_d     = vb_sh;

    if (byte_ok) begin
      pos      = SPACE_MAX - vb_sh;
      window_d = (win_sh & ~(WINDOW_WIDTH'(8'hFF) << pos)) | (WINDOW_WIDTH'(inv_byte) << pos);
      vb_d     = vb_sh + VB_8;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (in_last) state_d = TAIL;
    end

    if ((state_d == FILL) && (vb_d >= VB_16)) state_d = RUN;
    if (pad_d > PAD_LIM) ovr_d = 1'b1;

    if (start) begin
      state_d  = FILL;
      window_d = '1;
      vb_d     = '0;
      pad_d    = '0;
      cnt_d    = '0;
      ovr_d    = 1'b0;
      unf_d    = 1'b0;
    end

    win_valid_d = (state_d == TAIL) ||
                  (((state_d == FILL) || (state_d == RUN)) && (vb_d >= VB_16));
    win_out_d   = window_d[WINDOW_WIDTH-1 -: 16];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      window_q    <= '1;
      vb_q        <= '0;
      pad_q       <= '0;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
      unf_q       <= 1'b0;
      win_valid_q <= 1'b0;
      win_out_q   <= '1;
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      vb_q        <= vb_d;
      pad_q       <= pad_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
      unf_q       <= unf_d;
      win_valid_q <= win_valid_d;
      win_out_q   <= win_out_d;
    end
  end

  assign win_out        = win_out_q;
  assign win_valid      = win_valid_q;
  assign bytes_consumed = cnt_q;
  assign tail_active    = (state_q == TAIL);
  assign overread       = ovr_q;
  assign underflow_err  = unf_q;

endmodule
